// File: rtl/button_debounce.sv
// Two-flop synchroniser plus per-line debounce for the board push-buttons.
// Emits clean levels, sticky write-one-to-clear press flags and a pending summary.
module button_debounce #(
    parameter int unsigned N_BUTTONS       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons_clean,
    output logic [N_BUTTONS-1:0] press_event,
    input  logic [N_BUTTONS-1:0] event_clear,
    output logic                 event_pending
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] r_sync1;
    logic [N_BUTTONS-1:0] r_sync2;
    logic [N_BUTTONS-1:0] r_stable;
    logic [N_BUTTONS-1:0] r_press;
    logic                 r_pending;
    logic [CW-1:0]        r_cnt [N_BUTTONS];

    logic [N_BUTTONS-1:0] w_stable_nxt;
    logic [N_BUTTONS-1:0] w_rise;
    logic [N_BUTTONS-1:0] w_press_nxt;
    logic [CW-1:0]        w_cnt_nxt [N_BUTTONS];

    // A line flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        w_stable_nxt = r_stable;
        w_rise       = '0;
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_nxt[i] = r_sync2[i];
                    w_rise[i]       = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
        // A press landing on the same edge as its clear strobe must survive.
        w_press_nxt = w_rise | (r_press & ~event_clear);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_press   <= '0;
            r_pending <= 1'b0;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= buttons_raw;
            r_sync2   <= r_sync1;
            r_stable  <= w_stable_nxt;
            r_press   <= w_press_nxt;
            r_pending <= |r_press;
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign buttons_clean = r_stable;
    assign press_event   = r_press;
    assign event_pending = r_pending;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4; expected output
// states are queued per edge and checked by an independent monitor.
module tb_button_debounce;

    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] buttons_raw;
    logic [NB-1:0] buttons_clean;
    logic [NB-1:0] press_event;
    logic [NB-1:0] event_clear;
    logic          event_pending;

    button_debounce #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons_raw   (buttons_raw),
        .buttons_clean (buttons_clean),
        .press_event   (press_event),
        .event_clear   (event_clear),
        .event_pending (event_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] clean;
        logic [NB-1:0] pev;
        logic          pend;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    cyc = 0;
    int    tests = 0;
    int    failed = 0;
    bit    done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are sampled on the falling edge after each active edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests++;
                if (e.cyc < cyc) begin
                    failed++;
                    $display("FAIL %s: expectation for edge %0d not checked (now %0d)", nm, e.cyc, cyc);
                end else if ({buttons_clean, press_event, event_pending} !== {e.clean, e.pev, e.pend}) begin
                    failed++;
                    $display("FAIL %s @edge %0d: got clean=%b press=%b pend=%b, expected clean=%b press=%b pend=%b",
                             nm, cyc, buttons_clean, press_event, event_pending, e.clean, e.pev, e.pend);
                end
            end
        end
    end

    // Queue the expected state after each of the next n edges, advancing one edge at a time.
    task automatic run(input int n, input logic [NB-1:0] c, input logic [NB-1:0] p,
                       input logic pd, input string nm);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc   = cyc + 1;
            e.clean = c;
            e.pev   = p;
            e.pend  = pd;
            exp_q.push_back(e);
            name_q.push_back(nm);
            @(negedge clk);
        end
    endtask

    initial begin
        reset       = 1'b0;
        buttons_raw = 4'hF;
        event_clear = 4'h0;
        run(3, 4'h0, 4'h0, 1'b0, "reset_hold");

        reset = 1'b1;
        run(5, 4'h0, 4'h0, 1'b0, "release_wait");
        run(1, 4'hF, 4'hF, 1'b0, "release_rise");
        run(1, 4'hF, 4'hF, 1'b1, "release_pend");

        buttons_raw = 4'h0;
        event_clear = 4'hF;
        run(1, 4'hF, 4'h0, 1'b1, "clear_all");
        event_clear = 4'h0;
        run(4, 4'hF, 4'h0, 1'b0, "all_release_wait");
        run(1, 4'h0, 4'h0, 1'b0, "all_release_fall");

        buttons_raw = 4'h1;
        run(5, 4'h0, 4'h0, 1'b0, "b0_press_wait");
        run(1, 4'h1, 4'h1, 1'b0, "b0_press_rise");
        run(1, 4'h1, 4'h1, 1'b1, "b0_pend");
        buttons_raw = 4'h0;
        run(5, 4'h1, 4'h1, 1'b1, "b0_release_wait");
        run(1, 4'h0, 4'h1, 1'b1, "b0_release_keeps_event");

        for (int i = 0; i < 40; i++) begin
            buttons_raw = (i % 4 != 3) ? 4'h2 : 4'h0;
            run(1, 4'h0, 4'h1, 1'b1, "b1_glitch");
        end
        buttons_raw = 4'h0;
        run(6, 4'h0, 4'h1, 1'b1, "b1_glitch_tail");

        buttons_raw = 4'h4;
        run(5, 4'h0, 4'h1, 1'b1, "b2_press_wait");
        run(1, 4'h4, 4'h5, 1'b1, "b2_press_rise");
        event_clear = 4'h1;
        run(1, 4'h4, 4'h4, 1'b1, "clear_b0_only");
        event_clear = 4'h0;
        buttons_raw = 4'h0;
        run(5, 4'h4, 4'h4, 1'b1, "b2_release_wait");
        run(1, 4'h0, 4'h4, 1'b1, "b2_release_fall");
        buttons_raw = 4'h4;
        run(5, 4'h0, 4'h4, 1'b1, "b2_repress_wait");
        event_clear = 4'h4;
        run(1, 4'h4, 4'h4, 1'b1, "set_beats_clear");
        event_clear = 4'h0;
        run(1, 4'h4, 4'h4, 1'b1, "b2_hold");
        event_clear = 4'h4;
        run(1, 4'h4, 4'h0, 1'b1, "clear_b2");
        event_clear = 4'h0;
        run(1, 4'h4, 4'h0, 1'b0, "pend_drop");

        buttons_raw = 4'hC;
        run(4, 4'h4, 4'h0, 1'b0, "b3_partial_count");
        reset = 1'b0;
        run(1, 4'h0, 4'h0, 1'b0, "mid_count_reset");
        reset = 1'b1;
        run(5, 4'h0, 4'h0, 1'b0, "post_reset_wait");
        run(1, 4'hC, 4'hC, 1'b0, "post_reset_rise");
        run(1, 4'hC, 4'hC, 1'b1, "post_reset_pend");

        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, got %0d checks, expected completion", tests);
            $fatal(1, "timeout");
        end
    end

endmodule
